// File: rtl/dram_model_pkg.sv
// Shared types and constants for the DRAM response model.
package dram_model_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int unsigned LAT_W   = 8;
  localparam int unsigned COUNT_W = 16;
  localparam logic [COUNT_W-1:0] CNT_SAT = '1;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/dram_resp_model_if.sv
// Core <-> DRAM model request/response bus with status outputs.
interface dram_resp_model_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 24
) ();
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_data_out;
  logic              dram_req_read;
  logic              dram_req_write;
  logic [DATA_W-1:0] dram_data_in;
  logic              dram_data_valid;
  logic              dram_write_complete;
  logic              oor_err;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;

  modport master (
    output dram_addr, dram_data_out, dram_req_read, dram_req_write,
    input  dram_data_in, dram_data_valid, dram_write_complete,
           oor_err, rd_count, wr_count
  );

  modport slave (
    input  dram_addr, dram_data_out, dram_req_read, dram_req_write,
    output dram_data_in, dram_data_valid, dram_write_complete,
           oor_err, rd_count, wr_count
  );
endinterface

// File: rtl/dram_model_mem.sv
// Word array with synchronous write plus a per-word written bitmap cleared by reset.
module dram_model_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [MEM_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              written_o
);
  localparam int unsigned DEPTH = 2 ** MEM_AW;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  written_q;

  // Array has no reset; the bitmap masks stale contents after reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_q <= '0;
    end else if (we_i) begin
      written_q[addr_i] <= 1'b1;
    end
  end

  assign rdata_o   = mem_q[addr_i];
  assign written_o = written_q[addr_i];
endmodule

// File: rtl/dram_resp_model.sv
// Latency-accurate DRAM stand-in: write-priority arbitration, storage, OOR flag, counters.
module dram_resp_model
  import dram_model_pkg::*;
#(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ADDR_W       = 24,
  parameter int unsigned       MEM_AW       = 10,
  parameter int unsigned       RD_LAT       = 8,
  parameter int unsigned       WR_LAT       = 4,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = 32'hDEADBEEF,
  parameter int unsigned       WRAP         = 1
) (
  input logic               clk,
  input logic               rst_n,
  dram_resp_model_if.slave  bus
);
  localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WR_LAT - 1);

  state_e              state_q, state_d;
  logic [LAT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                valid_q, valid_d;
  logic                wcmp_q, wcmp_d;
  logic                oor_q, oor_d;
  logic [COUNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [COUNT_W-1:0]  wr_cnt_q, wr_cnt_d;

  logic                upper_nz;
  logic                out_of_range;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_written;

  if (ADDR_W > MEM_AW) begin : g_upper
    assign upper_nz = |addr_q[ADDR_W-1:MEM_AW];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  // With WRAP set, upper bits alias onto the array and are never flagged.
  assign out_of_range = (WRAP == 0) && upper_nz;

  dram_model_mem #(
    .DATA_W (DATA_W),
    .MEM_AW (MEM_AW)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (mem_we),
    .addr_i    (addr_q[MEM_AW-1:0]),
    .wdata_i   (wdata_q),
    .rdata_o   (mem_rdata),
    .written_o (mem_written)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    valid_d  = 1'b0;
    wcmp_d   = 1'b0;
    oor_d    = oor_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    mem_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.dram_req_write) begin
          addr_d  = bus.dram_addr;
          wdata_d = bus.dram_data_out;
          cnt_d   = WR_LOAD;
          state_d = WR_WAIT;
        end else if (bus.dram_req_read) begin
          addr_d  = bus.dram_addr;
          cnt_d   = RD_LOAD;
          state_d = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          mem_we   = !out_of_range;
          oor_d    = oor_q | out_of_range;
          wcmp_d   = 1'b1;
          wr_cnt_d = sat_inc(wr_cnt_q);
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d  = (mem_written && !out_of_range) ? mem_rdata : DEFAULT_DATA;
          oor_d    = oor_q | out_of_range;
          valid_d  = 1'b1;
          rd_cnt_d = sat_inc(rd_cnt_q);
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
      wcmp_q   <= 1'b0;
      oor_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      wcmp_q   <= wcmp_d;
      oor_q    <= oor_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.dram_data_in        = rdata_q;
  assign bus.dram_data_valid     = valid_q;
  assign bus.dram_write_complete = wcmp_q;
  assign bus.oor_err             = oor_q;
  assign bus.rd_count            = rd_cnt_q;
  assign bus.wr_count            = wr_cnt_q;
endmodule

// File: tb/tb_dram_resp_model.sv
// Directed bench driving a WRAP=0 and a WRAP=1 model with identical stimulus.
module tb_dram_resp_model;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 24;
  localparam int unsigned MAW = 10;
  localparam int unsigned RDL = 8;
  localparam int unsigned WRL = 4;
  localparam logic [31:0] DEF = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_resp_model_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  dram_resp_model_if #(.DATA_W(DW), .ADDR_W(AW)) busw ();

  assign busw.dram_addr      = bus0.dram_addr;
  assign busw.dram_data_out  = bus0.dram_data_out;
  assign busw.dram_req_read  = bus0.dram_req_read;
  assign busw.dram_req_write = bus0.dram_req_write;

  dram_resp_model #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_AW(MAW), .RD_LAT(RDL), .WR_LAT(WRL),
    .DEFAULT_DATA(DEF), .WRAP(0)
  ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus0));

  dram_resp_model #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_AW(MAW), .RD_LAT(RDL), .WR_LAT(WRL),
    .DEFAULT_DATA(DEF), .WRAP(1)
  ) u_dut_wrap (.clk(clk), .rst_n(rst_n), .bus(busw));

  int n_checks = 0;
  int n_fails  = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_rd_count"},   32'(bus0.rd_count), 32'(exp_rd));
    check({tag, "_wr_count"},   32'(bus0.wr_count), 32'(exp_wr));
    check({tag, "_rd_count_w"}, 32'(busw.rd_count), 32'(exp_rd));
    check({tag, "_wr_count_w"}, 32'(busw.wr_count), 32'(exp_wr));
  endtask

  // Counts posedges until the chosen pulse is seen on the WRAP=0 model.
  task automatic wait_pulse(input bit is_write, input bit scramble, output int cycles);
    logic seen;
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 300) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (scramble && cycles == 1) begin
        bus0.dram_addr     = ~bus0.dram_addr;
        bus0.dram_data_out = ~bus0.dram_data_out;
      end
      seen = is_write ? bus0.dram_write_complete : bus0.dram_data_valid;
    end
    check(is_write ? "wrap_wr_pulse_align" : "wrap_rd_pulse_align",
          32'(is_write ? busw.dram_write_complete : busw.dram_data_valid), 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int cyc;
    bus0.dram_addr      = addr;
    bus0.dram_data_out  = data;
    bus0.dram_req_write = 1'b1;
    wait_pulse(1'b1, 1'b1, cyc);
    check("wr_latency", 32'(cyc - 1), 32'(WRL));
    bus0.dram_req_write = 1'b0;
    exp_wr++;
    @(posedge clk);
    @(negedge clk);
    check("wr_pulse_width", 32'(bus0.dram_write_complete), 32'd0);
    check_counts("wr");
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp0,
                         input logic [DW-1:0] expw);
    int cyc;
    bus0.dram_addr     = addr;
    bus0.dram_req_read = 1'b1;
    wait_pulse(1'b0, 1'b1, cyc);
    check("rd_latency", 32'(cyc - 1), 32'(RDL));
    check("rd_data",   bus0.dram_data_in, exp0);
    check("rd_data_w", busw.dram_data_in, expw);
    bus0.dram_req_read = 1'b0;
    exp_rd++;
    @(posedge clk);
    @(negedge clk);
    check("rd_pulse_width", 32'(bus0.dram_data_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("rd_data_hold", bus0.dram_data_in, exp0);
    check_counts("rd");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc_w, cyc_r, stray;
    bus0.dram_addr      = '0;
    bus0.dram_data_out  = '0;
    bus0.dram_req_read  = 1'b0;
    bus0.dram_req_write = 1'b0;

    // Reset then idle
    #20;
    check("rst_data_in", bus0.dram_data_in, 32'd0);
    check("rst_valid",   32'(bus0.dram_data_valid), 32'd0);
    check("rst_wcmp",    32'(bus0.dram_write_complete), 32'd0);
    check("rst_oor",     32'(bus0.oor_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_data_in", bus0.dram_data_in, 32'd0);
    check("idle_valid",   32'(bus0.dram_data_valid), 32'd0);
    check("idle_wcmp",    32'(bus0.dram_write_complete), 32'd0);
    check_counts("idle");

    // Unwritten read
    do_read(24'h000005, DEF, DEF);

    // Write then read
    do_write(24'h000010, 32'h12345678);
    do_read(24'h000010, 32'h12345678, 32'h12345678);

    // Simultaneous requests: write first, read accepted WR_LAT+2 after write
    bus0.dram_addr      = 24'h000020;
    bus0.dram_data_out  = 32'hCAFEF00D;
    bus0.dram_req_write = 1'b1;
    bus0.dram_req_read  = 1'b1;
    wait_pulse(1'b1, 1'b0, cyc_w);
    check("sim_wr_latency", 32'(cyc_w - 1), 32'(WRL));
    check("sim_no_early_valid", 32'(bus0.dram_data_valid), 32'd0);
    bus0.dram_req_write = 1'b0;
    exp_wr++;
    wait_pulse(1'b0, 1'b0, cyc_r);
    check("sim_rd_accept_gap", 32'(WRL + cyc_r - RDL), 32'(WRL + 2));
    check("sim_rd_data", bus0.dram_data_in, 32'hCAFEF00D);
    bus0.dram_req_read = 1'b0;
    exp_rd++;
    @(negedge clk);
    check_counts("sim");

    // Out of range write aliases to word 0 only on the WRAP=1 model
    do_write(24'h000400, 32'h00000001);
    check("oor_set",  32'(bus0.oor_err), 32'd1);
    check("oor_wrap", 32'(busw.oor_err), 32'd0);
    do_read(24'h000000, DEF, 32'h00000001);
    check("oor_sticky", 32'(bus0.oor_err), 32'd1);

    // Reset mid-read
    bus0.dram_addr     = 24'h000010;
    bus0.dram_req_read = 1'b1;
    @(posedge clk);
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus0.dram_data_valid) stray++;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_data_in", bus0.dram_data_in, 32'd0);
    check("midrst_oor",     32'(bus0.oor_err), 32'd0);
    exp_rd = 0;
    exp_wr = 0;
    check_counts("midrst");
    bus0.dram_req_read = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus0.dram_data_valid || busw.dram_data_valid) stray++;
    end
    check("midrst_no_pulse", 32'(stray), 32'd0);
    do_read(24'h000010, DEF, DEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
